// File: rtl/control_unit.sv
// K&S 16-bit processor multi-cycle control FSM.
// Drives data_path strobes and counts retired instructions.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;

  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int RETIRED_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [RETIRED_W-1:0]    retired_count
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALTED  = 3'd4
  } state_t;

  state_t state, next_state;
  logic   take_branch;
  logic   unused_flags;

  assign unused_flags = unsigned_overflow ^ signed_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  // Saturating: every instruction leaving EXECUTE retires, HALT included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count <= '0;
    end else if (state == EXECUTE && retired_count != '1) begin
      retired_count <= retired_count + RETIRED_W'(1);
    end
  end

  always_comb begin
    take_branch = 1'b0;
    unique case (decoded_instruction)
      I_BRANCH: take_branch = 1'b1;
      I_BZERO:  take_branch = zero_op;
      I_BNZERO: take_branch = ~zero_op;
      I_BNEG:   take_branch = neg_op;
      I_BNNEG:  take_branch = ~neg_op;
      default:  take_branch = 1'b0;
    endcase
  end

  always_comb begin
    next_state       = state;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_OR;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    unique case (state)
      INIT: begin
        next_state = FETCH;
      end
      FETCH: begin
        ir_enable  = 1'b1;
        pc_enable  = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        next_state = EXECUTE;
      end
      EXECUTE: begin
        next_state = FETCH;
        unique case (decoded_instruction)
          I_LOAD: begin
            addr_sel         = 1'b1;
            c_sel            = 1'b1;
            write_reg_enable = 1'b1;
          end
          I_STORE: begin
            addr_sel         = 1'b1;
            ram_write_enable = 1'b1;
          end
          I_ADD, I_SUB, I_AND, I_OR: begin
            write_reg_enable = 1'b1;
            flags_reg_enable = 1'b1;
            unique case (decoded_instruction)
              I_ADD:   operation = ALU_ADD;
              I_SUB:   operation = ALU_SUB;
              I_AND:   operation = ALU_AND;
              default: operation = ALU_OR;
            endcase
          end
          I_MOVE: begin
            operation        = ALU_OR;
            write_reg_enable = 1'b1;
          end
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG: begin
            branch    = take_branch;
            pc_enable = take_branch;
          end
          I_HALT: begin
            next_state = HALTED;
          end
          default: ;
        endcase
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: begin
        next_state = INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized and directed bench for control_unit against
// a cycle-count based model of the instruction sequencing rules.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  decoded_instruction_type ins = I_NOP;
  logic zf = 1'b0;
  logic nf = 1'b0;
  logic uo = 1'b0;
  logic so = 1'b0;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;
  logic [15:0] retired_count;

  logic rst4 = 1'b1;
  logic b4, pe4, ie4, as4, cs4, wr4, fr4, rw4, h4;
  logic [1:0] op4;
  logic [3:0] rc4;

  int checks = 0;
  int errors = 0;

  // Model: cycles since reset release, halted flag, retirements.
  int mc = 0;
  bit mhalted = 0;
  int mret = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst(rst), .decoded_instruction(ins),
    .zero_op(zf), .neg_op(nf),
    .unsigned_overflow(uo), .signed_overflow(so),
    .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable),
    .ram_write_enable(ram_write_enable), .halt(halt),
    .retired_count(retired_count)
  );

  control_unit #(.RETIRED_W(4)) dut4 (
    .clk(clk), .rst(rst4), .decoded_instruction(I_NOP),
    .zero_op(1'b0), .neg_op(1'b0),
    .unsigned_overflow(1'b0), .signed_overflow(1'b0),
    .branch(b4), .pc_enable(pe4), .ir_enable(ie4),
    .addr_sel(as4), .c_sel(cs4), .operation(op4),
    .write_reg_enable(wr4), .flags_reg_enable(fr4),
    .ram_write_enable(rw4), .halt(h4), .retired_count(rc4)
  );

  // 0 init, 1 fetch, 2 decode, 3 execute, 4 halted
  function automatic int role();
    if (mhalted) return 4;
    if (mc == 0) return 0;
    return 1 + ((mc - 1) % 3);
  endfunction

  function automatic logic [10:0] dut_vec();
    return {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
            write_reg_enable, flags_reg_enable, ram_write_enable, halt};
  endfunction

  function automatic logic [10:0] exp_vec(int r, decoded_instruction_type i,
                                          logic z, logic n);
    logic br, pe, ie, as, cs, wr, fr, rw, h, tk;
    logic [1:0] op;
    {br, pe, ie, as, cs, wr, fr, rw, h} = '0;
    op = 2'b00;
    tk = 1'b0;
    if (r == 1) begin
      ie = 1; pe = 1;
    end else if (r == 4) begin
      h = 1;
    end else if (r == 3) begin
      case (i)
        I_LOAD:  begin as = 1; cs = 1; wr = 1; end
        I_STORE: begin as = 1; rw = 1; end
        I_ADD:   begin op = 2'b01; wr = 1; fr = 1; end
        I_SUB:   begin op = 2'b10; wr = 1; fr = 1; end
        I_AND:   begin op = 2'b11; wr = 1; fr = 1; end
        I_OR:    begin op = 2'b00; wr = 1; fr = 1; end
        I_MOVE:  begin op = 2'b00; wr = 1; end
        I_BRANCH: tk = 1;
        I_BZERO:  tk = z;
        I_BNZERO: tk = !z;
        I_BNEG:   tk = n;
        I_BNNEG:  tk = !n;
        default: ;
      endcase
      br = tk; pe = tk;
    end
    return {br, pe, ie, as, cs, op, wr, fr, rw, h};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h (mc=%0d)", tag, got, exp, mc);
    end
  endtask

  // Entered at posedge+1; leaves at next posedge+1.
  task automatic cycle(decoded_instruction_type i, logic z, logic n);
    int r;
    r = role();
    ins = i; zf = z; nf = n;
    uo = 1'($urandom); so = 1'($urandom);
    #2;
    chk($sformatf("outs_r%0d_%s", r, i.name()),
        32'(dut_vec()), 32'(exp_vec(r, i, z, n)));
    chk("retired", 32'(retired_count), 32'(mret));
    chk("ir_wr_excl", 32'(ir_enable & write_reg_enable), 32'd0);
    @(posedge clk);
    if (r == 3) begin
      if (mret < 16'hFFFF) mret++;
      if (i == I_HALT) mhalted = 1;
    end
    if (!mhalted) mc++;
    #1;
  endtask

  task automatic run_instr(decoded_instruction_type i, logic z, logic n);
    int r;
    do begin
      r = role();
      cycle(i, z, n);
    end while (r != 3);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    mc = 0; mhalted = 0; mret = 0;
    chk("rst_outs", 32'(dut_vec()), 32'd0);
    chk("rst_retired", 32'(retired_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    decoded_instruction_type ri;
    logic [3:0] v;
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    apply_reset();

    for (int k = 0; k < 13; k++) cycle(I_NOP, 1'b0, 1'b0);

    run_instr(I_SUB, 1'b0, 1'b0);
    run_instr(I_MOVE, 1'b1, 1'b1);
    run_instr(I_LOAD, 1'b0, 1'b0);
    run_instr(I_STORE, 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      run_instr(I_BRANCH, 1'(p), 1'(p));
      run_instr(I_BZERO, 1'(p), 1'(~p));
      run_instr(I_BNZERO, 1'(p), 1'(~p));
      run_instr(I_BNEG, 1'(~p), 1'(p));
      run_instr(I_BNNEG, 1'(~p), 1'(p));
    end

    for (int k = 0; k < 40; k++) begin
      v = 4'($urandom_range(0, 15));
      if (v == 4'd13) v = 4'd0;
      ri = decoded_instruction_type'(v);
      run_instr(ri, 1'($urandom), 1'($urandom));
    end

    run_instr(I_HALT, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      v = 4'($urandom_range(0, 15));
      ri = decoded_instruction_type'(v);
      cycle(ri, 1'($urandom), 1'($urandom));
    end

    apply_reset();
    run_instr(I_ADD, 1'b0, 1'b0);
    run_instr(I_OR, 1'b0, 1'b0);

    while (role() != 3) cycle(I_STORE, 1'b0, 1'b0);
    ins = I_STORE;
    #1;
    chk("store_we_before_rst", 32'(ram_write_enable), 32'd1);
    rst = 1'b1;
    #1;
    chk("store_we_async_drop", 32'(ram_write_enable), 32'd0);
    apply_reset();
    run_instr(I_NOP, 1'b0, 1'b0);

    chk("sat4_count", 32'(rc4), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
